// File: rtl/hwag_tooth_capture_if.sv
`timescale 1ns/1ps
`default_nettype none
// hwag_tooth_capture_if: control inputs and strobe/measurement outputs of the tooth capture stage.
// Rev 1.0
interface hwag_tooth_capture_if #(
   parameter int PCNT_WIDTH = 24,
   parameter int TCNT_WIDTH = 8
);
   logic                  srst;
   logic                  cap_in;
   logic                  edge_sel;
   logic                  tooth_stb;
   logic                  gap_stb;
   logic [PCNT_WIDTH-1:0] period;
   logic [TCNT_WIDTH-1:0] tooth_num;
   logic                  synced;
   logic                  err_stb;
   logic                  stall;

   modport master (
      output srst, cap_in, edge_sel,
      input  tooth_stb, gap_stb, period, tooth_num, synced, err_stb, stall
   );

   modport slave (
      input  srst, cap_in, edge_sel,
      output tooth_stb, gap_stb, period, tooth_num, synced, err_stb, stall
   );
endinterface
`default_nettype wire

// File: rtl/hwag_tooth_capture.sv
`timescale 1ns/1ps
`default_nettype none
// hwag_tooth_capture: crank input sync/filter, tooth period measurement, gap search and sync tracking.
// Rev 1.0
module hwag_tooth_capture #(
   parameter int PCNT_WIDTH = 24,
   parameter int TCNT_WIDTH = 8,
   parameter int FILT_LEN   = 3,
   parameter int TEETH      = 58
) (
   input  logic                 clk,
   input  logic                 rst,
   hwag_tooth_capture_if.slave  cap_if
);

   localparam int                    C_RCNT_W     = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   localparam logic [C_RCNT_W-1:0]   C_RUN_LAST   = C_RCNT_W'(FILT_LEN - 1);
   localparam logic [PCNT_WIDTH-1:0] C_PCNT_MAX   = '1;
   localparam logic [PCNT_WIDTH-1:0] C_PCNT_PRE   = C_PCNT_MAX - 1'b1;
   localparam logic [TCNT_WIDTH-1:0] C_LAST_TOOTH = TCNT_WIDTH'(TEETH - 1);

   typedef enum logic [1:0] {
      ST_UNSYNC = 2'd0,
      ST_SEEK   = 2'd1,
      ST_VERIFY = 2'd2,
      ST_SYNCED = 2'd3
   } state_t;

   logic                  ff1_q, ff2_q;
   logic                  lvl_q, lvl_d;
   logic                  lvl_dly_q;
   logic [C_RCNT_W-1:0]   run_q, run_d;
   state_t                state_q, state_d;
   logic [PCNT_WIDTH-1:0] pcnt_q, pcnt_d;
   logic [PCNT_WIDTH-1:0] period_q, period_d;
   logic [PCNT_WIDTH-1:0] prev_period_q, prev_period_d;
   logic                  prev_valid_q, prev_valid_d;
   logic [TCNT_WIDTH-1:0] tooth_q, tooth_d;
   logic                  stall_q, stall_d;
   logic                  synced_q, synced_d;
   logic                  tooth_stb_q, tooth_stb_d;
   logic                  gap_stb_q, gap_stb_d;
   logic                  err_stb_q, err_stb_d;

   logic                  w_edge;
   logic                  w_is_gap;
   logic [PCNT_WIDTH-1:0] w_pinc;

   // The synchroniser survives srst so a level already present on the pin is not lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ff1_q <= 1'b0;
         ff2_q <= 1'b0;
      end else begin
         ff1_q <= cap_if.cap_in;
         ff2_q <= ff1_q;
      end
   end

   always_comb begin
      lvl_d = lvl_q;
      run_d = run_q;
      if (ff2_q != lvl_q) begin
         if (run_q == C_RUN_LAST) begin
            lvl_d = ff2_q;
            run_d = '0;
         end else begin
            run_d = run_q + 1'b1;
         end
      end else begin
         run_d = '0;
      end
   end

   assign w_edge   = (lvl_q != lvl_dly_q) && (lvl_q != cap_if.edge_sel);
   assign w_pinc   = (pcnt_q == C_PCNT_MAX) ? C_PCNT_MAX : pcnt_q + 1'b1;
   // Widened compare so 2*prev_period can never wrap.
   assign w_is_gap = prev_valid_q && ({1'b0, w_pinc} > {prev_period_q, 1'b0});

   always_comb begin
      state_d       = state_q;
      pcnt_d        = w_pinc;
      period_d      = period_q;
      prev_period_d = prev_period_q;
      prev_valid_d  = prev_valid_q;
      tooth_d       = tooth_q;
      stall_d       = stall_q;
      tooth_stb_d   = 1'b0;
      gap_stb_d     = 1'b0;
      err_stb_d     = 1'b0;

      if (w_edge) begin
         pcnt_d        = '0;
         period_d      = w_pinc;
         prev_period_d = w_pinc;
         prev_valid_d  = 1'b1;
         tooth_stb_d   = 1'b1;
         stall_d       = 1'b0;
         case (state_q)
            ST_UNSYNC: begin
               prev_valid_d = 1'b0;
               tooth_d      = '0;
               state_d      = ST_SEEK;
            end
            ST_SEEK: begin
               tooth_d = '0;
               if (w_is_gap) begin
                  gap_stb_d = 1'b1;
                  state_d   = ST_VERIFY;
               end
            end
            default: begin
               if (w_is_gap) begin
                  gap_stb_d = 1'b1;
                  tooth_d   = '0;
                  if (tooth_q == C_LAST_TOOTH) begin
                     state_d = ST_SYNCED;
                  end else begin
                     err_stb_d = 1'b1;
                     state_d   = ST_VERIFY;
                  end
               end else if (tooth_q >= C_LAST_TOOTH) begin
                  err_stb_d = 1'b1;
                  tooth_d   = '0;
                  state_d   = ST_SEEK;
               end else begin
                  tooth_d = tooth_q + 1'b1;
               end
            end
         endcase
      end else if (pcnt_q == C_PCNT_PRE) begin
         // Counter is about to saturate: engine considered stopped.
         stall_d   = 1'b1;
         err_stb_d = (state_q == ST_VERIFY) || (state_q == ST_SYNCED);
         state_d   = ST_UNSYNC;
      end

      synced_d = (state_d == ST_SYNCED);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lvl_q         <= 1'b0;
         lvl_dly_q     <= 1'b0;
         run_q         <= '0;
         state_q       <= ST_UNSYNC;
         pcnt_q        <= '0;
         period_q      <= '0;
         prev_period_q <= '0;
         prev_valid_q  <= 1'b0;
         tooth_q       <= '0;
         stall_q       <= 1'b0;
         synced_q      <= 1'b0;
         tooth_stb_q   <= 1'b0;
         gap_stb_q     <= 1'b0;
         err_stb_q     <= 1'b0;
      end else if (cap_if.srst) begin
         lvl_q         <= 1'b0;
         lvl_dly_q     <= 1'b0;
         run_q         <= '0;
         state_q       <= ST_UNSYNC;
         pcnt_q        <= '0;
         period_q      <= '0;
         prev_period_q <= '0;
         prev_valid_q  <= 1'b0;
         tooth_q       <= '0;
         stall_q       <= 1'b0;
         synced_q      <= 1'b0;
         tooth_stb_q   <= 1'b0;
         gap_stb_q     <= 1'b0;
         err_stb_q     <= 1'b0;
      end else begin
         lvl_q         <= lvl_d;
         lvl_dly_q     <= lvl_q;
         run_q         <= run_d;
         state_q       <= state_d;
         pcnt_q        <= pcnt_d;
         period_q      <= period_d;
         prev_period_q <= prev_period_d;
         prev_valid_q  <= prev_valid_d;
         tooth_q       <= tooth_d;
         stall_q       <= stall_d;
         synced_q      <= synced_d;
         tooth_stb_q   <= tooth_stb_d;
         gap_stb_q     <= gap_stb_d;
         err_stb_q     <= err_stb_d;
      end
   end

   assign cap_if.tooth_stb = tooth_stb_q;
   assign cap_if.gap_stb   = gap_stb_q;
   assign cap_if.period    = period_q;
   assign cap_if.tooth_num = tooth_q;
   assign cap_if.synced    = synced_q;
   assign cap_if.err_stb   = err_stb_q;
   assign cap_if.stall     = stall_q;

endmodule
`default_nettype wire

// File: doc/hwag_tooth_capture.md
Name: hwag_tooth_capture

Overview:
- Front-end capture stage of the hardware angle generator, sitting directly upstream of the tooth/angle counters.
- Synchronises and filters the crank sensor input and detects active tooth edges.
- Measures the tooth period and finds the missing-tooth gap.
- Tracks tooth number and synchronisation state, and produces the single-cycle strobes that drive downstream counter sload/srst/ena.

Parameters:
PCNT_WIDTH, 24, width of period counter and period output
TCNT_WIDTH, 8, width of tooth number output
FILT_LEN, 3, consecutive agreeing samples needed to change filtered level (>=1)
TEETH, 58, physical teeth per revolution (edges per revolution incl. first-after-gap), < 2**TCNT_WIDTH

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
srst  in  1  synchronous clear, same effect as rst except the input synchroniser is not cleared
cap_in  in  1  raw sensor input, asynchronous to clk
edge_sel  in  1  0: rising edge active, 1: falling edge active (static during operation)
tooth_stb  out  1  one-cycle pulse per accepted active edge
gap_stb  out  1  one-cycle pulse, coincident with tooth_stb, when that edge closes a gap period
period  out  PCNT_WIDTH  cycles between last two active edges, updated with tooth_stb
tooth_num  out  TCNT_WIDTH  0 on gap edge, +1 per normal edge, updated with tooth_stb
synced  out  1  high while state is SYNCED
err_stb  out  1  one-cycle pulse on sync loss
stall  out  1  period counter saturated (engine stopped)

Behaviour:
- Reset (rst async, srst sync): all outputs 0, state UNSYNC, pcnt 0, prev_period 0, prev_valid 0, filter level 0, filter run count 0. rst also clears the 2-FF synchroniser.
- Synchroniser: cap_in -> ff1 -> ff2.
- Filter: level flips only after FILT_LEN consecutive ff2 samples that differ from the current level. Any agreeing sample resets the run count.
- Edge: active transition of the filtered level per edge_sel. Outputs are registered.
- Latency: cap_in stable change before edge k gives tooth_stb high in the cycle after edge k+FILT_LEN+2. Pulses shorter than FILT_LEN cycles are never seen.
- pcnt increments every cycle and saturates at all-ones. On an active edge: period <= pcnt+1 (saturating), then pcnt <= 0. Two edges N cycles apart therefore report period=N.
- Gap test: gap = prev_valid && (period_new > 2*prev_period), evaluated at PCNT_WIDTH+1 bits with no overflow. After every edge, prev_period <= period_new and prev_valid <= 1.
- States:
  - UNSYNC: on edge: tooth_stb, prev_valid<=0, go SEEK. No gap test, tooth_num 0.
  - SEEK: on edge: tooth_stb. If gap: gap_stb, tooth_num<=0, go VERIFY. Else tooth_num unchanged at 0.
  - VERIFY / SYNCED:
    - Normal edge with tooth_num < TEETH-1: tooth_num+1.
    - Gap edge with tooth_num == TEETH-1: gap_stb, tooth_num<=0, go SYNCED (stay SYNCED).
    - Gap edge with tooth_num < TEETH-1: err_stb, gap_stb, tooth_num<=0, go VERIFY.
    - Normal edge with tooth_num == TEETH-1: err_stb, tooth_num<=0, go SEEK.
- Stall:
  - pcnt reaching all-ones with no edge in that cycle: stall<=1, synced<=0. err_stb pulses if the state was VERIFY or SYNCED. State goes UNSYNC.
  - The next edge clears stall, reports period=all-ones, and is processed as an UNSYNC edge.
  - An edge in the same cycle pcnt saturates counts as an edge: no stall.
- srst has priority over edges in the same cycle; that edge is discarded.
- err_stb and gap_stb never occur without tooth_stb, except the stall-entry err_stb.
- synced is registered from state and changes in the same cycle as the corresponding strobe.
- edge_sel change while running: the next opposite transition may yield a short period. This is allowed and recovers through the error paths.

Test Plan:
- TB parameters for all scenarios: TEETH=6, FILT_LEN=3, PCNT_WIDTH=12, edge_sel=0.
- Reset, cap_in glitches high for 2 cycles -> no tooth_stb. Held high 3+ cycles -> tooth_stb exactly 6 cycles after cap_in rise.
- Teeth every 100 cycles, then 300-cycle gap -> gap_stb with period=300, tooth_num=0. Next 5 edges give tooth_num 1..5, period=100. Next 300-cycle gap -> synced=1, tooth_num=0.
- Synced, gap inserted after tooth_num=3 -> err_stb, gap_stb, synced=0, tooth_num=0. Then 5 normal teeth plus gap -> synced=1.
- Synced, gap omitted (edge arrives at 100 cycles with tooth_num=5) -> err_stb, synced=0, tooth_num=0, back to SEEK.
- Synced, input frozen -> stall=1 and err_stb exactly 4095 cycles after last edge. Next edge -> stall=0, period=4095, synced=0.
- srst mid-revolution, and separately async rst pulse mid-cycle -> all outputs 0 next cycle (rst immediately). Resync needs a full gap-to-gap revolution.
